// File: rtl/text_display_sequencer_pkg.sv
// Shared definitions for the text display sequencer: state encoding and default widths.
package text_display_sequencer_pkg;

    localparam int MSG_W_DEF   = 4;
    localparam int DWELL_W_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_SHOW,
        ST_NEXT,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/text_display_sequencer.sv
// Steps a message index through a programmed list, holding each message for a
// programmed number of display-timer expiries. All outputs are registered.
//
// state | meaning
// IDLE  | waiting for start
// ARM   | timer held clear for one cycle, message shown, expiry count cleared
// SHOW  | timer enabled, counting expiries toward the latched dwell
// NEXT  | timer held clear, pick next index or finish
// DONE  | one-cycle seq_done pulse, then back to IDLE
module text_display_sequencer
    import text_display_sequencer_pkg::*;
#(
    parameter int MSG_W   = MSG_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MSG_W-1:0]   msg_count,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               loop,
    input  logic               skip,
    input  logic               abort,
    input  logic               timer_done,
    output logic               timer_en,
    output logic [MSG_W-1:0]   msg_index,
    output logic               msg_valid,
    output logic               busy,
    output logic               seq_done
);

    seq_state_t         state, state_nxt;
    logic [MSG_W-1:0]   count_q, count_nxt;
    logic [MSG_W-1:0]   index_nxt;
    logic [DWELL_W-1:0] dwell_q, dwell_nxt;
    logic [DWELL_W-1:0] hits_q, hits_nxt, hits_inc;
    logic               loop_q, loop_nxt;
    logic               active_nxt;

    assign hits_inc   = hits_q + DWELL_W'(1);
    assign active_nxt = (state_nxt == ST_ARM) || (state_nxt == ST_SHOW) ||
                        (state_nxt == ST_NEXT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            count_q   <= '0;
            dwell_q   <= '0;
            loop_q    <= 1'b0;
            hits_q    <= '0;
            msg_index <= '0;
            timer_en  <= 1'b0;
            msg_valid <= 1'b0;
            busy      <= 1'b0;
            seq_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            count_q   <= count_nxt;
            dwell_q   <= dwell_nxt;
            loop_q    <= loop_nxt;
            hits_q    <= hits_nxt;
            msg_index <= index_nxt;
            timer_en  <= (state_nxt == ST_SHOW);
            msg_valid <= active_nxt;
            busy      <= active_nxt;
            seq_done  <= (state_nxt == ST_DONE);
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count_q;
        dwell_nxt = dwell_q;
        loop_nxt  = loop_q;
        hits_nxt  = hits_q;
        index_nxt = msg_index;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (msg_count != '0) begin
                        count_nxt = msg_count;
                        dwell_nxt = (dwell == '0) ? DWELL_W'(1) : dwell;
                        loop_nxt  = loop;
                        index_nxt = '0;
                        state_nxt = ST_ARM;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_ARM: begin
                if (abort) begin
                    state_nxt = ST_DONE;
                end else begin
                    hits_nxt  = '0;
                    state_nxt = ST_SHOW;
                end
            end
            ST_SHOW: begin
                // abort beats skip beats a same-cycle expiry
                if (abort) begin
                    state_nxt = ST_DONE;
                end else if (skip) begin
                    state_nxt = ST_NEXT;
                end else if (timer_done) begin
                    hits_nxt = hits_inc;
                    if (hits_inc == dwell_q) begin
                        state_nxt = ST_NEXT;
                    end
                end
            end
            ST_NEXT: begin
                if (abort) begin
                    state_nxt = ST_DONE;
                end else if (msg_index == count_q - MSG_W'(1)) begin
                    if (loop_q) begin
                        index_nxt = '0;
                        state_nxt = ST_ARM;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end else begin
                    index_nxt = msg_index + MSG_W'(1);
                    state_nxt = ST_ARM;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_text_display_sequencer.sv
// Bench for text_display_sequencer: directed scenarios plus random control pulses,
// checked every cycle against a sequence-level reference model.
module tb_text_display_sequencer;

    localparam int MSG_W   = 4;
    localparam int DWELL_W = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               start, skip, abort, loop, timer_done;
    logic [MSG_W-1:0]   msg_count;
    logic [DWELL_W-1:0] dwell;
    logic               timer_en, msg_valid, busy, seq_done;
    logic [MSG_W-1:0]   msg_index;

    always #5 clk = ~clk;

    text_display_sequencer #(.MSG_W(MSG_W), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .reset(reset), .start(start), .msg_count(msg_count),
        .dwell(dwell), .loop(loop), .skip(skip), .abort(abort),
        .timer_done(timer_done), .timer_en(timer_en), .msg_index(msg_index),
        .msg_valid(msg_valid), .busy(busy), .seq_done(seq_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 timer clearing before a message,
    // 2 message timing, 3 timer clearing after a message, 4 finish pulse.
    int m_ph, m_idx, m_cnt, m_dw, m_loop, m_hits, m_ends;
    int tcnt;
    logic glitch;
    int obs_q[$];
    int n_done_seen, run, maxrun;
    logic valid_seen, prev_valid;
    logic [MSG_W-1:0] prev_idx;

    task automatic model_reset();
        m_ph = 0; m_idx = 0; m_cnt = 0; m_dw = 0; m_loop = 0; m_hits = 0;
        tcnt = 0;
    endtask

    task automatic model_step();
        case (m_ph)
            0: if (start) begin
                   if (msg_count != 0) begin
                       m_cnt = msg_count; m_dw = (dwell == 0) ? 1 : dwell;
                       m_loop = loop; m_idx = 0; m_ph = 1;
                   end else m_ph = 4;
               end
            1: if (abort) m_ph = 4; else begin m_hits = 0; m_ph = 2; end
            2: if (abort) m_ph = 4;
               else if (skip) begin m_ph = 3; m_ends++; end
               else if (timer_done) begin
                   m_hits++;
                   if (m_hits >= m_dw) begin m_ph = 3; m_ends++; end
               end
            3: if (abort) m_ph = 4;
               else if (m_idx == m_cnt - 1) begin
                   if (m_loop != 0) begin m_idx = 0; m_ph = 1; end else m_ph = 4;
               end else begin m_idx++; m_ph = 1; end
            default: m_ph = 0;
        endcase
    endtask

    task automatic scn_begin();
        obs_q.delete(); n_done_seen = 0; valid_seen = 0; maxrun = 0; run = 0; m_ends = 0;
    endtask

    task automatic step();
        timer_done = (timer_en && tcnt == 9) || glitch;
        model_step();
        if (timer_en) tcnt = (tcnt == 9) ? 0 : tcnt + 1; else tcnt = 0;
        @(posedge clk);
        @(negedge clk);
        chk("timer_en", timer_en, m_ph == 2);
        chk("msg_valid", msg_valid, m_ph >= 1 && m_ph <= 3);
        chk("busy", busy, m_ph >= 1 && m_ph <= 3);
        chk("seq_done", seq_done, m_ph == 4);
        chk("msg_index", msg_index, m_idx);
        if (seq_done) n_done_seen++;
        if (msg_valid) valid_seen = 1;
        if (msg_valid && (!prev_valid || msg_index != prev_idx)) obs_q.push_back(msg_index);
        prev_valid = msg_valid; prev_idx = msg_index;
        run = timer_en ? run + 1 : 0;
        if (run > maxrun) maxrun = run;
        start = 0; skip = 0; abort = 0; glitch = 0;
    endtask

    task automatic launch(input int cnt, input int dw, input logic lp);
        msg_count = MSG_W'(cnt); dwell = DWELL_W'(dw); loop = lp; start = 1;
        step();
    endtask

    task automatic run_to_idle(input int limit);
        int k = 0;
        do begin step(); k++; end while (m_ph != 0 && k < limit);
        if (m_ph != 0) chk("idle_timeout", 1, 0);
    endtask

    task automatic run_to_phase(input int ph, input int limit);
        int k = 0;
        while (m_ph != ph && k < limit) begin step(); k++; end
        if (m_ph != ph) chk("phase_timeout", m_ph, ph);
    endtask

    task automatic chk_seq(input string tag, input int exp[$]);
        chk({tag, "_len"}, obs_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < obs_q.size(); i++)
            chk({tag, "_idx"}, obs_q[i], exp[i]);
    endtask

    initial begin
        reset = 1; start = 0; skip = 0; abort = 0; loop = 0; timer_done = 0;
        msg_count = '0; dwell = '0; glitch = 0; prev_valid = 0; prev_idx = '0;
        model_reset(); scn_begin();
        @(negedge clk);
        chk("rst_timer_en", timer_en, 0);
        chk("rst_msg_valid", msg_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_seq_done", seq_done, 0);
        chk("rst_msg_index", msg_index, 0);
        reset = 0;

        // three messages, one expiry each
        scn_begin(); launch(3, 1, 0); run_to_idle(200);
        chk_seq("s1_seq", '{0, 1, 2});
        chk("s1_done_pulses", n_done_seen, 1);
        chk("s1_en_run", maxrun, 10);

        // two messages, three expiries each: timer stays enabled across expiries
        scn_begin(); launch(2, 3, 0); run_to_idle(300);
        chk_seq("s2_seq", '{0, 1});
        chk("s2_en_run", maxrun, 30);

        // looping list aborted after five dwells
        scn_begin(); launch(2, 1, 1);
        begin
            int k = 0;
            while (!(m_ph == 3 && m_ends >= 5) && k < 400) begin step(); k++; end
            if (!(m_ph == 3 && m_ends >= 5)) chk("s3_timeout", 1, 0);
        end
        abort = 1; step();
        chk("s3_abort_done", seq_done, 1);
        chk("s3_abort_valid", msg_valid, 0);
        run_to_idle(10);
        chk_seq("s3_seq", '{0, 1, 0, 1, 0});

        // skip early, then skip colliding with an expiry: one advance each
        scn_begin(); launch(3, 2, 0); run_to_phase(2, 10);
        repeat (4) step();
        skip = 1; step();
        run_to_phase(2, 10);
        repeat (9) step();
        skip = 1; glitch = 1; step();
        run_to_idle(200);
        chk_seq("s4_seq", '{0, 1, 2});
        chk("s4_done_pulses", n_done_seen, 1);

        // empty list: finish pulse only
        scn_begin(); launch(0, 1, 0); run_to_idle(5); repeat (3) step();
        chk("s5_valid_seen", valid_seen, 0);
        chk("s5_done_pulses", n_done_seen, 1);

        // stray expiries in idle and arm, restart attempt while busy
        scn_begin(); glitch = 1; step();
        launch(1, 2, 0); glitch = 1; step();
        repeat (3) step();
        msg_count = 4'd5; start = 1; step();
        run_to_idle(200);
        chk_seq("s6_seq", '{0});
        chk("s6_en_run", maxrun, 20);

        // asynchronous reset in the middle of a message
        scn_begin(); launch(3, 1, 0); run_to_phase(2, 10); repeat (3) step();
        #2 reset = 1;
        #1;
        chk("arst_timer_en", timer_en, 0);
        chk("arst_msg_valid", msg_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_msg_index", msg_index, 0);
        model_reset();
        @(negedge clk);
        chk("arst_no_done", seq_done, 0);
        reset = 0; prev_valid = 0;
        scn_begin(); launch(2, 1, 0); run_to_idle(200);
        chk_seq("s7_seq", '{0, 1});

        // random control traffic
        scn_begin();
        for (int i = 0; i < 4000; i++) begin
            start     = ($urandom_range(0, 19) == 0);
            msg_count = MSG_W'($urandom_range(0, 15));
            dwell     = DWELL_W'($urandom_range(0, 7));
            loop      = $urandom_range(0, 1);
            skip      = ($urandom_range(0, 39) == 0);
            abort     = ($urandom_range(0, 149) == 0);
            glitch    = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
